// File: rtl/aer_event_scheduler.sv
// Round-robin AER arbiter: packs {ts, x, y, pol} for one of 64 pixel requesters per cycle, 4-phase ack per pixel.
// Latency: req sampled at edge N with the slot free -> valid_o/ack_o set in cycle N+1; all outputs registered.
// Backpressure: word held stable while valid_o && !ready_i; reloads in the same edge as a transfer (no bubble).
// Optional build macro AER_SCHED_TS_SATURATE_EN: timestamp sticks at all-ones instead of wrapping.
module aer_event_scheduler #(
    parameter int TS_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [63:0]           req_i,
    input  logic [63:0]           pol_i,
    output logic [63:0]           ack_o,
    output logic [TS_WIDTH+6:0]   data_out_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    logic [TS_WIDTH-1:0] ts;
    logic [5:0]          ptr;
    logic [63:0]         eligible;
    logic [63:0]         rotated;
    logic [5:0]          offset;
    logic [5:0]          grant_idx;
    logic                load;

    // Pick the first eligible pixel at or after ptr: rotate so ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        eligible = req_i & ~ack_o;
        rotated  = '0;
        for (int i = 0; i < 64; i++) begin
            rotated[i] = eligible[ptr + 6'(i)];
        end
        offset = '0;
        for (int i = 63; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = 6'(i);
            end
        end
        grant_idx = ptr + offset;
        load      = (!valid_o || ready_i) && (|eligible);
    end

    // Free-running timestamp; zero in the first cycle after reset is released.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts <= '0;
        end else begin
`ifdef AER_SCHED_TS_SATURATE_EN
            if (ts != {TS_WIDTH{1'b1}}) begin
                ts <= ts + {{(TS_WIDTH-1){1'b0}}, 1'b1};
            end
`else
            ts <= ts + {{(TS_WIDTH-1){1'b0}}, 1'b1};
`endif
        end
    end

    // Round-robin pointer moves just past the most recent winner (6-bit add wraps 63 -> 0).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= grant_idx + 6'd1;
        end
    end

    // Acks drop once the pixel withdraws its request; a fresh grant sets its own bit in the same edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ack_o <= '0;
        end else begin
            ack_o <= (ack_o & req_i) | (load ? (64'd1 << grant_idx) : 64'd0);
        end
    end

    // Output register: load on a free or draining slot, otherwise clear valid after a transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o    <= 1'b0;
            data_out_o <= '0;
        end else if (load) begin
            valid_o    <= 1'b1;
            data_out_o <= {ts, grant_idx, pol_i[grant_idx]};
        end else if (ready_i) begin
            valid_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aer_event_scheduler.sv
// Bench for aer_event_scheduler with a narrow timestamp so wrap/saturation is reached quickly.
// Stimulus task applies inputs on the falling edge and advances a behavioural model that queues expected words.
// A monitor pops the queue on every observed transfer; directed phases add fixed-value checks.
module tb_aer_event_scheduler;

    localparam int TW = 8;
    localparam int DW = TW + 7;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [63:0]   req_i;
    logic [63:0]   pol_i;
    logic [63:0]   ack_o;
    logic [DW-1:0] data_out_o;
    logic          valid_o;
    logic          ready_i;

    always #5 clk = ~clk;

    aer_event_scheduler #(.TS_WIDTH(TW)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .pol_i      (pol_i),
        .ack_o      (ack_o),
        .data_out_o (data_out_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];
    int            dut_grants[64];

    // Reference model state: what the block should present right now.
    logic          m_known = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [63:0]   m_ack;
    int            m_ptr;
    int            cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Timestamp expected in the cycle that is c cycles after reset release.
    function automatic logic [TW-1:0] ts_of(input int c);
`ifdef AER_SCHED_TS_SATURATE_EN
        return (c >= (1 << TW) - 1) ? TW'((1 << TW) - 1) : TW'(c);
`else
        return TW'(c);
`endif
    endfunction

    // One clock: verify model state, apply inputs, advance the model, return just after the rising edge.
    task automatic cycle(input logic rst, input logic [63:0] r, input logic [63:0] p, input logic rdy);
        logic [63:0] elig;
        logic [63:0] nack;
        logic        ld;
        int          k;
        @(negedge clk);
        if (m_known) begin
            check("valid_o", {63'd0, valid_o}, {63'd0, m_valid});
            check("ack_o", ack_o, m_ack);
            check("data_out_o", {49'd0, data_out_o}, {49'd0, m_data});
        end
        reset_i = rst;
        req_i   = r;
        pol_i   = p;
        ready_i = rdy;
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_ack   = '0;
            m_ptr   = 0;
            cyc     = 0;
            exp_q.delete();
        end else begin
            elig = r & ~m_ack;
            ld   = (!m_valid || rdy) && (elig != 64'd0);
            nack = m_ack & r;
            if (ld) begin
                k = -1;
                for (int i = 0; i < 64; i++) begin
                    if (k < 0 && elig[(m_ptr + i) % 64]) k = (m_ptr + i) % 64;
                end
                m_data  = {ts_of(cyc), 6'(k), p[k]};
                exp_q.push_back(m_data);
                m_valid = 1'b1;
                nack[k] = 1'b1;
                m_ptr   = (k + 1) % 64;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            m_ack = nack;
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    // Randomised 4-phase requesters: raise when idle, drop after ack (sticky pixels never drop).
    task automatic rand_cycles(input int n, input logic [63:0] active, input logic [63:0] sticky, input int rdy_pct);
        logic [63:0] r;
        logic [63:0] p;
        logic        rdy;
        for (int c = 0; c < n; c++) begin
            r = req_i;
            p = pol_i;
            for (int k = 0; k < 64; k++) begin
                if (r[k] && m_ack[k] && !sticky[k]) begin
                    if ($urandom_range(0, 1) == 1) r[k] = 1'b0;
                end else if (active[k] && !r[k] && !m_ack[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r[k] = 1'b1;
                        p[k] = 1'($urandom_range(0, 1));
                    end
                end
            end
            rdy = ($urandom_range(0, 99) < rdy_pct);
            cycle(1'b0, r, p, rdy);
        end
    endtask

    // Monitor: every transfer seen on the output must match the oldest expected word.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        #1;
        if (reset_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL transfer: got %h expected no event", data_out_o);
            end else begin
                e = exp_q.pop_front();
                if (data_out_o !== e) begin
                    fails++;
                    $display("FAIL transfer: got %h expected %h", data_out_o, e);
                end
                dut_grants[data_out_o[6:1]]++;
            end
        end
    end

    initial begin
        logic [63:0]   r;
        logic [63:0]   r3;
        logic [DW-1:0] held;
        int            others;

        reset_i = 1'b1;
        req_i   = '0;
        pol_i   = '0;
        ready_i = 1'b0;
        foreach (dut_grants[i]) dut_grants[i] = 0;

        // Reset state
        cycle(1'b1, 64'd0, 64'd0, 1'b0);
        cycle(1'b1, 64'd0, 64'd0, 1'b0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_ack", ack_o, 64'd0);
        check("rst_data", {49'd0, data_out_o}, 64'd0);

        // Single event for pixel 19 requested in the cycle with ts=5
        repeat (5) cycle(1'b0, 64'd0, 64'd0, 1'b1);
        r = 64'd1 << 19;
        cycle(1'b0, r, r, 1'b1);
        check("single_data", {49'd0, data_out_o}, {49'd0, 8'd5, 3'd2, 3'd3, 1'b1});
        check("single_ack", ack_o, r);
        cycle(1'b0, r, r, 1'b1);
        cycle(1'b0, 64'd0, 64'd0, 1'b1);
        check("single_ack_release", ack_o, 64'd0);
        check("single_valid_drop", {63'd0, valid_o}, 64'd0);

        // Round-robin order from ptr=0, including the 63 -> 0 wrap
        cycle(1'b1, 64'd0, 64'd0, 1'b0);
        r3 = (64'd1 << 0) | (64'd1 << 5) | (64'd1 << 63);
        cycle(1'b0, r3, 64'd0, 1'b1);
        check("rr_first", {58'd0, data_out_o[6:1]}, 64'd0);
        cycle(1'b0, r3, 64'd0, 1'b1);
        check("rr_second", {58'd0, data_out_o[6:1]}, 64'd5);
        cycle(1'b0, r3, 64'd0, 1'b1);
        check("rr_third", {58'd0, data_out_o[6:1]}, 64'd63);
        cycle(1'b0, 64'd0, 64'd0, 1'b1);
        cycle(1'b0, r3, 64'd0, 1'b1);
        check("rr_wrap", {58'd0, data_out_o[6:1]}, 64'd0);
        rand_cycles(60, r3, 64'd0, 100);

        // Backpressure: hold the index-2 word, then reload index 7 on the draining edge
        cycle(1'b0, 64'd0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 64'd0, 1'b1);
        r = 64'd1 << 2;
        cycle(1'b0, r, 64'd0, 1'b1);
        held = data_out_o;
        r = r | (64'd1 << 7);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, r, 64'd0, 1'b0);
            check("bp_hold_data", {49'd0, data_out_o}, {49'd0, held});
            check("bp_hold_valid", {63'd0, valid_o}, 64'd1);
        end
        cycle(1'b0, r, 64'd0, 1'b1);
        check("bp_reload_idx", {58'd0, data_out_o[6:1]}, 64'd7);
        check("bp_reload_valid", {63'd0, valid_o}, 64'd1);
        cycle(1'b0, 64'd0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 64'd0, 1'b1);

        // Ack masking: pixel 12 never withdraws and must be served exactly once
        foreach (dut_grants[i]) dut_grants[i] = 0;
        r = 64'd1 << 12;
        cycle(1'b0, r, 64'd0, 1'b1);
        rand_cycles(200, r | 64'h00F0_0000_0F00_00F0, r, 70);
        cycle(1'b0, req_i, pol_i, 1'b1);
        cycle(1'b0, req_i & r, pol_i, 1'b1);
        check("mask_once", 64'(dut_grants[12]), 64'd1);
        check("mask_ack_held", {63'd0, ack_o[12]}, 64'd1);
        others = 0;
        for (int i = 0; i < 64; i++) if (i != 12) others += dut_grants[i];
        check("mask_others_served", {63'd0, others > 0}, 64'd1);
        repeat (3) cycle(1'b0, 64'd0, 64'd0, 1'b1);

        // Timestamp boundary: events in the all-ones cycle and the one after
        cycle(1'b1, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 300 && cyc != (1 << TW) - 1; i++) cycle(1'b0, 64'd0, 64'd0, 1'b1);
        cycle(1'b0, 64'd1 << 1, 64'd0, 1'b1);
        check("ts_max", {56'd0, data_out_o[DW-1:7]}, 64'hFF);
        cycle(1'b0, (64'd1 << 1) | (64'd1 << 2), 64'd0, 1'b1);
        check("ts_next_idx", {58'd0, data_out_o[6:1]}, 64'd2);
`ifdef AER_SCHED_TS_SATURATE_EN
        check("ts_next", {56'd0, data_out_o[DW-1:7]}, 64'hFF);
`else
        check("ts_next", {56'd0, data_out_o[DW-1:7]}, 64'h00);
`endif
        repeat (2) cycle(1'b0, 64'd0, 64'd0, 1'b1);

        // Reset mid-operation discards the held word and all acks
        r = 64'd1 << 3;
        cycle(1'b0, r, 64'd0, 1'b0);
        check("mid_valid", {63'd0, valid_o}, 64'd1);
        check("mid_ack", ack_o, r);
        cycle(1'b1, r, 64'd0, 1'b0);
        check("mid_rst_valid", {63'd0, valid_o}, 64'd0);
        check("mid_rst_ack", ack_o, 64'd0);
        check("mid_rst_data", {49'd0, data_out_o}, 64'd0);
        cycle(1'b0, r, 64'd0, 1'b1);
        check("post_rst_event", {49'd0, data_out_o}, {49'd0, 8'd0, 6'd3, 1'b0});
        repeat (2) cycle(1'b0, 64'd0, 64'd0, 1'b1);

        // Long random run across several timestamp wraps
        rand_cycles(1500, {$urandom, $urandom}, 64'd0, 60);

        // Drain and confirm every expected word left the block
        repeat (4) cycle(1'b0, 64'd0, 64'd0, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aer_event_scheduler.md
# aer_event_scheduler

Arbitrates per-pixel event requests from the 8x8 event-based-camera array onto a single AER output stream. Each granted event is packed as {timestamp, x, y, polarity} using a free-running internal timestamp counter. The word is held in an output register under valid/ready flow control, and the winning pixel is acknowledged with a 4-phase req/ack handshake. The block sits between the pixel array and the downstream event FIFO/serializer.

## Interface
- TS_WIDTH, 32, timestamp counter and field width; data_out_o width is TS_WIDTH+7.
- clk_i  in  1  single clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  64  pixel event request; index k = x*8 + y.
- pol_i  in  64  pixel polarity; sampled only for the granted index at capture.
- ack_o  out  64  per-pixel acknowledge (4-phase).
- data_out_o  out  TS_WIDTH+7  packed event {ts[TS_WIDTH-1:0], x[2:0], y[2:0], pol}.
- valid_o  out  1  data_out_o holds an event.
- ready_i  in  1  downstream accepts when valid_o && ready_i.

## Operation
- Timestamp counter ts:
  - Equals 0 in the first cycle with reset_i low.
  - Increments by 1 every cycle.
  - Wraps from all-ones to 0 (see Configuration).
- Eligible vector: req_i & ~ack_o.
- Load condition: (!valid_o || ready_i) && |eligible.
- Round-robin selection:
  - Pointer ptr, 6 bits, reset 0.
  - Select the first eligible index scanning ptr, ptr+1, …, 63, 0, …, ptr-1.
  - After a grant to k, ptr <= k+1 mod 64; 63 wraps to 0.
- Capture at the edge where the load condition holds, grant k:
  - data_out_o <= {ts, k[5:3], k[2:0], pol_i[k]}.
  - valid_o <= 1.
  - ack_o[k] <= 1.
- Ack release: ack_o[k] clears at the first edge where req_i[k]==0 is sampled. While set, index k is masked from arbitration.
- Multiple ack_o bits may be high at once, one per in-flight pixel.
- Output hold: when valid_o && !ready_i, data_out_o and valid_o are held stable.
- Transfer without reload: valid_o && ready_i with no eligible request gives valid_o <= 0 next cycle; data_out_o keeps its last value.
- Transfer with reload: valid_o && ready_i with an eligible request loads the new event in the same edge, giving back-to-back output with no bubble.
- Simultaneous clear and grant: an ack clear for index j and a grant to index k≠j in the same edge both take effect.
- ready_i is ignored while valid_o==0.
- Reset values:
  - valid_o=0, data_out_o=0, ack_o=0.
  - ptr=0, ts=0.
  - Reset mid-operation discards the held event and drops all acks; requesters re-arbitrate after release.

## Timing
- Latency: req_i[k] sampled at edge N with the slot free → valid_o=1 and ack_o[k]=1 in cycle N+1. The ts field equals the ts value in cycle N.
- Throughput: 1 event/cycle with ready_i held high and distinct eligible requesters.
- Minimum per-pixel cycle:
  - req high at edge N → ack after N.
  - Requester drops req, sampled at edge M → ack low after M.
  - The pixel may re-request after ack falls.
- No combinational path from req_i/ready_i to any output. All outputs are registered.

## Configuration
- AER_SCHED_TS_SATURATE_EN:
  - Defined: ts stops at 2^TS_WIDTH-1 and stays there until reset.
  - Undefined (default): ts wraps to 0 modulo 2^TS_WIDTH.

## Test plan
- Single event: reset 2 cycles, release; at cycle 5 set req_i[19]=1, pol_i[19]=1, ready_i=1 → cycle 6: valid_o=1, ack_o[19]=1, data_out_o={32'd5,3'd2,3'd3,1'b1}. Drop req at cycle 7 → ack_o[19]=0 from cycle 8.
- Round-robin fairness: req_i[0], [5] and [63] held high, each requester dropping and re-raising req after its ack falls, ready_i=1 → grant order 0, 5, 63, 0, 5, … with ptr wrap 63→0.
- Backpressure: event captured, ready_i=0 for 4 cycles while req_i[7] is pending → data_out_o/valid_o stable. ready_i=1 → the index-7 event is loaded in the same edge, with no bubble.
- Ack masking: req_i[12] held high and never dropped → exactly one event for index 12; ack_o[12] stays 1; other requesters are still served.
- Timestamp boundary: force ts near 2^32-1, events at ts=0xFFFFFFFF and the next cycle → second event ts=0; with AER_SCHED_TS_SATURATE_EN defined → 0xFFFFFFFF.
- Reset mid-operation: valid_o=1, ack_o[3]=1, ready_i=0; assert reset_i one cycle → next cycle valid_o=0, ack_o=0, data_out_o=0; the first event after release carries a ts measured from 0.
